// File: rtl/m_count_ones_seq.sv
// Time-multiplexed popcount of a DATA_WIDTH word using one shared CHUNK_WIDTH-bit counter.
// Optional feature macro: COUNT_ONES_SEQ_THRESH_EN (adds i_thresh / o_over threshold compare).

module m_count_ones #(
    parameter int WIDTH = 42,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] data,
    output logic [CNT_W-1:0] count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < WIDTH; i++) begin
            count = count + CNT_W'(data[i]);
        end
    end

endmodule

module m_count_ones_seq #(
    parameter int DATA_WIDTH  = 240,
    parameter int CHUNK_WIDTH = 42,
    localparam int CW         = $clog2(DATA_WIDTH + 1)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [CW-1:0]         o_count,
`ifdef COUNT_ONES_SEQ_THRESH_EN
    input  logic [CW-1:0]         i_thresh,
    output logic                  o_over,
`endif
    output logic                  o_busy
);

    localparam int N    = (CHUNK_WIDTH < 1) ? 1 : (DATA_WIDTH + CHUNK_WIDTH - 1) / CHUNK_WIDTH;
    localparam int PADW = N * CHUNK_WIDTH;
    localparam int IW   = (N > 1) ? $clog2(N) : 1;
    localparam int PW   = $clog2(CHUNK_WIDTH + 1);

    generate
        if (CHUNK_WIDTH < 1 || CHUNK_WIDTH > DATA_WIDTH) begin : g_bad_chunk
            $error("m_count_ones_seq: CHUNK_WIDTH must be in 1..DATA_WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    logic [PADW-1:0] data_r;
    logic [IW-1:0]   idx;
    logic [CW-1:0]   acc;
    logic [PW-1:0]   chunk_cnt;
    logic [CW-1:0]   sum;
`ifdef COUNT_ONES_SEQ_THRESH_EN
    logic [CW-1:0]   thresh_r;
`endif

    // The word is shifted down one chunk per RUN cycle, so the counter always sees the low bits;
    // padding bits above DATA_WIDTH are zero from the load.
    m_count_ones #(.WIDTH(CHUNK_WIDTH), .CNT_W(PW)) u_count (
        .data  (data_r[CHUNK_WIDTH-1:0]),
        .count (chunk_cnt)
    );

    assign sum = acc + CW'(chunk_cnt);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= IDLE;
            data_r   <= '0;
            idx      <= '0;
            acc      <= '0;
            o_ready  <= 1'b1;
            o_valid  <= 1'b0;
            o_count  <= '0;
            o_busy   <= 1'b0;
`ifdef COUNT_ONES_SEQ_THRESH_EN
            thresh_r <= '0;
            o_over   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid && o_ready) begin
                        data_r   <= PADW'(i_data);
                        idx      <= '0;
                        acc      <= '0;
                        o_ready  <= 1'b0;
                        o_busy   <= 1'b1;
`ifdef COUNT_ONES_SEQ_THRESH_EN
                        thresh_r <= i_thresh;
`endif
                        state    <= RUN;
                    end
                end
                RUN: begin
                    data_r <= data_r >> CHUNK_WIDTH;
                    idx    <= idx + IW'(1);
                    acc    <= sum;
                    if (idx == IW'(N - 1)) begin
                        o_count <= sum;
                        o_valid <= 1'b1;
`ifdef COUNT_ONES_SEQ_THRESH_EN
                        o_over  <= (sum >= thresh_r);
`endif
                        state   <= DONE;
                    end
                end
                DONE: begin
                    // o_ready stays low on the completing edge; a new word waits for IDLE.
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        o_ready <= 1'b1;
                        o_busy  <= 1'b0;
`ifdef COUNT_ONES_SEQ_THRESH_EN
                        o_over  <= 1'b0;
`endif
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
